// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads, tracks up to two in-flight responses and
// buffers them in a 2-entry prefetch FIFO. Define INSTR_FETCH_BYPASS_EN for 0-cycle response bypass.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

  logic [31:0] pc_r, pc_nxt_s;
  logic [1:0]  os_r, os_nxt_s;
  logic [1:0]  disc_r, disc_nxt_s;
  logic [1:0]  cnt_r, cnt_nxt_s, cnt_after_s;
  logic [31:0] head_data_r, head_data_nxt_s, head_pc_r, head_pc_nxt_s;
  logic [31:0] tail_data_r, tail_data_nxt_s, tail_pc_r, tail_pc_nxt_s;
  logic [31:0] iq0_r, iq0_nxt_s, iq1_r, iq1_nxt_s;
  logic [1:0]  iq_base_s;

  logic        grant_s, pop_s, drop_s, good_s, byp_s, push_s;
  logic [2:0]  inflight_s, occ_s, flush_disc_s;
  logic        unused_s;

  assign unused_s = ^redirect_pc_i[1:0];

  assign grant_s    = mem_req_o & mem_gnt_i;
  assign inflight_s = {1'b0, os_r} + {1'b0, disc_r};
  assign pop_s      = (cnt_r != 2'd0) & instr_ready_i;
  assign drop_s     = mem_rvalid_i & ((disc_r != 2'd0) | redirect_i);
  assign good_s     = mem_rvalid_i & ~drop_s;

`ifdef INSTR_FETCH_BYPASS_EN
  assign byp_s = good_s & (cnt_r == 2'd0);
`else
  assign byp_s = 1'b0;
`endif

  assign push_s = good_s & ~(byp_s & instr_ready_i);

  // An entry popped this cycle frees its slot before any new response can land.
  assign occ_s     = inflight_s + {1'b0, cnt_r} - {2'b00, pop_s};
  assign mem_req_o  = ~rst_i & (occ_s < DEPTH_C);
  assign mem_addr_o = pc_r;

  // Everything still in flight after this cycle (including a same-cycle grant) must be dropped.
  assign flush_disc_s = inflight_s + {2'b00, grant_s}
                      - {2'b00, mem_rvalid_i & (inflight_s != 3'd0)};

`ifdef INSTR_FETCH_BYPASS_EN
  assign instr_valid_o = (cnt_r != 2'd0) | byp_s;
  assign instr_o       = byp_s ? mem_rdata_i : head_data_r;
  assign instr_pc_o    = byp_s ? iq0_r : head_pc_r;
`else
  assign instr_valid_o = (cnt_r != 2'd0);
  assign instr_o       = head_data_r;
  assign instr_pc_o    = head_pc_r;
`endif

  // Next-state for fetch PC, in-flight bookkeeping, issue-PC queue and prefetch FIFO
  always_comb begin
    pc_nxt_s        = pc_r;
    os_nxt_s        = os_r;
    disc_nxt_s      = disc_r;
    cnt_nxt_s       = cnt_r;
    cnt_after_s     = cnt_r;
    iq_base_s       = os_r;
    iq0_nxt_s       = iq0_r;
    iq1_nxt_s       = iq1_r;
    head_data_nxt_s = head_data_r;
    head_pc_nxt_s   = head_pc_r;
    tail_data_nxt_s = tail_data_r;
    tail_pc_nxt_s   = tail_pc_r;

    if (redirect_i) begin
      pc_nxt_s   = {redirect_pc_i[31:2], 2'b00};
      os_nxt_s   = 2'd0;
      disc_nxt_s = flush_disc_s[1:0];
      cnt_nxt_s  = 2'd0;
    end else begin
      if (grant_s) begin
        pc_nxt_s = pc_r + 32'd4;
      end else begin
        pc_nxt_s = pc_r;
      end

      if (drop_s) begin
        disc_nxt_s = disc_r - 2'd1;
      end else begin
        disc_nxt_s = disc_r;
      end

      // Issue-PC queue: a good response retires the head, a grant appends at the tail.
      iq_base_s = os_r - {1'b0, good_s};
      if (good_s) begin
        iq0_nxt_s = iq1_r;
      end else begin
        iq0_nxt_s = iq0_r;
      end
      if (grant_s) begin
        if (iq_base_s == 2'd0) begin
          iq0_nxt_s = pc_r;
        end else begin
          iq1_nxt_s = pc_r;
        end
      end else begin
        iq1_nxt_s = iq1_r;
      end
      os_nxt_s = iq_base_s + {1'b0, grant_s};

      if (pop_s) begin
        head_data_nxt_s = tail_data_r;
        head_pc_nxt_s   = tail_pc_r;
        cnt_after_s     = cnt_r - 2'd1;
      end else begin
        cnt_after_s     = cnt_r;
      end
      if (push_s) begin
        if (cnt_after_s == 2'd0) begin
          head_data_nxt_s = mem_rdata_i;
          head_pc_nxt_s   = iq0_r;
        end else begin
          tail_data_nxt_s = mem_rdata_i;
          tail_pc_nxt_s   = iq0_r;
        end
        cnt_nxt_s = cnt_after_s + 2'd1;
      end else begin
        cnt_nxt_s = cnt_after_s;
      end
    end
  end

  // State registers; reset abandons in-flight reads by moving them to the discard count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_r        <= RESET_PC;
      os_r        <= 2'd0;
      disc_r      <= flush_disc_s[1:0];
      cnt_r       <= 2'd0;
      iq0_r       <= 32'h0000_0000;
      iq1_r       <= 32'h0000_0000;
      head_data_r <= 32'h0000_0000;
      head_pc_r   <= 32'h0000_0000;
      tail_data_r <= 32'h0000_0000;
      tail_pc_r   <= 32'h0000_0000;
    end else begin
      pc_r        <= pc_nxt_s;
      os_r        <= os_nxt_s;
      disc_r      <= disc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      iq0_r       <= iq0_nxt_s;
      iq1_r       <= iq1_nxt_s;
      head_data_r <= head_data_nxt_s;
      head_pc_r   <= head_pc_nxt_s;
      tail_data_r <= tail_data_nxt_s;
      tail_pc_r   <= tail_pc_nxt_s;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a 1-cycle-latency in-order memory model.
module tb_instr_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic resp_en = 1'b1;

  logic [31:0] mem_q[$];
  logic [31:0] grant_addr[$];
  int          grant_cyc[$];
  logic [31:0] rx_pc[$];
  logic [31:0] rx_data[$];
  int          rx_cyc[$];
  int          rv_cyc[$];

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  // Memory: records grants, answers in order one cycle after each grant
  initial begin
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    forever begin
      @(posedge clk_i);
      if (!rst_i && mem_req_o && mem_gnt_i) begin
        mem_q.push_back(data_of(mem_addr_o));
        grant_addr.push_back(mem_addr_o);
        grant_cyc.push_back(cyc);
      end
      cyc++;
      #1;
      if (resp_en && mem_q.size() > 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_q.pop_front();
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
      end
    end
  end

  // Decoder side: logs accepted instructions and response cycles
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && instr_valid_o && instr_ready_i) begin
        rx_pc.push_back(instr_pc_o);
        rx_data.push_back(instr_o);
        rx_cyc.push_back(cyc);
      end
      if (mem_rvalid_i) rv_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic clear_logs();
    grant_addr.delete(); grant_cyc.delete();
    rx_pc.delete(); rx_data.delete(); rx_cyc.delete(); rv_cyc.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mem_gnt_i = 1'b0; instr_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0;
    tick(3);
    @(negedge clk_i);
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req_o); end
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid_o); end
    n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr_o); end
    n_checks++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", instr_pc_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL first_req got %b want 1", mem_req_o); end
    n_checks++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL first_addr got %h want 0", mem_addr_o); end
    tick(1);
    @(negedge clk_i);
    n_checks++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL held_addr got %h want 0", mem_addr_o); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk_i); #1;
    clear_logs();
    mem_gnt_i = 1'b1; instr_ready_i = 1'b1;
    tick(3);
    mem_gnt_i = 1'b0;
    tick(4);
    n_checks++; if (grant_addr.size() !== 3) begin n_fail++; $display("FAIL b2b_grants got %0d want 3", grant_addr.size()); end
    n_checks++; if (rx_pc.size() !== 3) begin n_fail++; $display("FAIL b2b_rx_count got %0d want 3", rx_pc.size()); end
    if (grant_addr.size() == 3 && rx_pc.size() == 3) begin
      n_checks++; if (grant_cyc[2] - grant_cyc[0] !== 2) begin n_fail++; $display("FAIL b2b_spacing got %0d want 2", grant_cyc[2] - grant_cyc[0]); end
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (grant_addr[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL b2b_addr%0d got %h want %h", i, grant_addr[i], 32'(4 * i)); end
        n_checks++; if (rx_pc[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL b2b_pc%0d got %h want %h", i, rx_pc[i], 32'(4 * i)); end
        n_checks++; if (rx_data[i] !== data_of(32'(4 * i))) begin n_fail++; $display("FAIL b2b_data%0d got %h want %h", i, rx_data[i], data_of(32'(4 * i))); end
      end
    end
  endtask

  task automatic test_stall();
    @(posedge clk_i); #1;
    clear_logs();
    mem_gnt_i = 1'b1; instr_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (k >= 2) begin
        n_checks++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid c%0d got %b want 1", k, instr_valid_o); end
        n_checks++; if (instr_pc_o !== 32'h0000_000C) begin n_fail++; $display("FAIL stall_pc c%0d got %h want 0000000c", k, instr_pc_o); end
        n_checks++; if (instr_o !== data_of(32'h0000_000C)) begin n_fail++; $display("FAIL stall_data c%0d got %h want %h", k, instr_o, data_of(32'h0000_000C)); end
      end
      if (k >= 3) begin
        n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req_full c%0d got %b want 0", k, mem_req_o); end
      end
      @(posedge clk_i); #1;
    end
    n_checks++; if (grant_addr.size() !== 2) begin n_fail++; $display("FAIL stall_grants got %0d want 2", grant_addr.size()); end
    instr_ready_i = 1'b1;
    tick(4);
    mem_gnt_i = 1'b0;
    tick(4);
    n_checks++; if (rx_pc.size() !== grant_addr.size() || rx_pc.size() < 3) begin n_fail++; $display("FAIL stall_noloss got %0d rx want %0d grants (>=3)", rx_pc.size(), grant_addr.size()); end
    for (int i = 0; i < rx_pc.size(); i++) begin
      n_checks++; if (rx_pc[i] !== 32'(12 + 4 * i)) begin n_fail++; $display("FAIL stall_seq%0d got %h want %h", i, rx_pc[i], 32'(12 + 4 * i)); end
      n_checks++; if (rx_data[i] !== data_of(32'(12 + 4 * i))) begin n_fail++; $display("FAIL stall_dat%0d got %h want %h", i, rx_data[i], data_of(32'(12 + 4 * i))); end
    end
  endtask

  task automatic test_redirect();
    @(negedge clk_i);
    resp_en = 1'b0;
    @(posedge clk_i); #1;
    clear_logs();
    mem_gnt_i = 1'b1; instr_ready_i = 1'b1;
    tick(3);
    n_checks++; if (grant_addr.size() !== 2) begin n_fail++; $display("FAIL redir_outstanding got %0d want 2", grant_addr.size()); end
    mem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    tick(1);
    redirect_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL redir_valid_after got %b want 0", instr_valid_o); end
    n_checks++; if (mem_addr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_addr got %h want 00000100", mem_addr_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL redir_req_blocked got %b want 0", mem_req_o); end
    resp_en = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b1;
    tick(4);
    mem_gnt_i = 1'b0;
    tick(4);
    n_checks++; if (rx_pc.size() < 1) begin n_fail++; $display("FAIL redir_rx_count got %0d want >=1", rx_pc.size()); end
    if (rx_pc.size() >= 1) begin
      n_checks++; if (rx_pc[0] !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_first_pc got %h want 00000100", rx_pc[0]); end
      n_checks++; if (rx_data[0] !== data_of(32'h0000_0100)) begin n_fail++; $display("FAIL redir_first_data got %h want %h", rx_data[0], data_of(32'h0000_0100)); end
    end
    if (grant_addr.size() >= 3) begin
      n_checks++; if (grant_addr[2] !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_grant_addr got %h want 00000100", grant_addr[2]); end
    end
  endtask

  task automatic test_wrap();
    @(posedge clk_i); #1;
    clear_logs();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE; mem_gnt_i = 1'b0; instr_ready_i = 1'b1;
    tick(1);
    redirect_i = 1'b0; mem_gnt_i = 1'b1;
    tick(2);
    mem_gnt_i = 1'b0;
    tick(4);
    n_checks++; if (grant_addr.size() !== 2 || rx_pc.size() !== 2) begin n_fail++; $display("FAIL wrap_count got %0d/%0d want 2/2", grant_addr.size(), rx_pc.size()); end
    if (grant_addr.size() == 2 && rx_pc.size() == 2) begin
      n_checks++; if (grant_addr[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 got %h want fffffffc", grant_addr[0]); end
      n_checks++; if (grant_addr[1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr1 got %h want 00000000", grant_addr[1]); end
      n_checks++; if (rx_pc[1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc1 got %h want 00000000", rx_pc[1]); end
    end
  endtask

  task automatic test_redirect_pop();
    int n_head;
    @(posedge clk_i); #1;
    clear_logs();
    instr_ready_i = 1'b0; mem_gnt_i = 1'b1;
    tick(4);
    mem_gnt_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0000_0004) begin n_fail++; $display("FAIL rpop_head got v=%b pc=%h want v=1 pc=00000004", instr_valid_o, instr_pc_o); end
    @(posedge clk_i); #1;
    instr_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    tick(1);
    redirect_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rpop_valid_after got %b want 0", instr_valid_o); end
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b1;
    tick(3);
    mem_gnt_i = 1'b0;
    tick(4);
    n_head = 0;
    foreach (rx_pc[i]) if (rx_pc[i] == 32'h0000_0004) n_head++;
    n_checks++; if (n_head !== 1) begin n_fail++; $display("FAIL rpop_once got %0d want 1", n_head); end
    if (rx_pc.size() >= 2) begin
      n_checks++; if (rx_pc[1] !== 32'h0000_0200) begin n_fail++; $display("FAIL rpop_no_stale got %h want 00000200", rx_pc[1]); end
    end else begin
      n_checks++; n_fail++; $display("FAIL rpop_rx_count got %0d want >=2", rx_pc.size());
    end
  endtask

  task automatic test_latency();
    int exp_lat;
`ifdef INSTR_FETCH_BYPASS_EN
    exp_lat = 0;
`else
    exp_lat = 1;
`endif
    @(posedge clk_i); #1;
    clear_logs();
    instr_ready_i = 1'b1; mem_gnt_i = 1'b1;
    tick(1);
    mem_gnt_i = 1'b0;
    tick(4);
    if (rv_cyc.size() == 1 && rx_cyc.size() == 1) begin
      n_checks++; if (rx_cyc[0] - rv_cyc[0] !== exp_lat) begin n_fail++; $display("FAIL latency got %0d want %0d", rx_cyc[0] - rv_cyc[0], exp_lat); end
      n_checks++; if (rx_data[0] !== data_of(rx_pc[0])) begin n_fail++; $display("FAIL latency_data got %h want %h", rx_data[0], data_of(rx_pc[0])); end
    end else begin
      n_checks++; n_fail++; $display("FAIL latency_count got rv=%0d rx=%0d want 1/1", rv_cyc.size(), rx_cyc.size());
    end
  endtask

  initial begin
    rst_i = 1'b1; mem_gnt_i = 1'b0; instr_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect();
    test_wrap();
    test_redirect_pop();
    test_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
